// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared state encoding and byte width for the program counter unit
package pc_unit_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, FIX_UP, FIX_DN} state_t;
endpackage

// File: rtl/pc_stage.sv
// pc_stage: staged load address and pending flag, committed by pc_unit on sync
module pc_stage
  import pc_unit_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [BYTE_W-1:0] data,
  input  logic              latch_lo,
  input  logic              latch_hi,
  input  logic              commit,
  output logic [ADDR_W-1:0] staged,
  output logic              pending
);
  logic [BYTE_W-1:0]        lo;
  logic [ADDR_W-BYTE_W-1:0] hi;
  assign staged = {hi, lo};
  // a latch in the commit cycle re-arms pending for the next sync
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      lo      <= '0;
      hi      <= '0;
      pending <= 1'b0;
    end else if (en) begin
      if (latch_lo) lo <= data;
      if (latch_hi) hi <= data[ADDR_W-BYTE_W-1:0];
      pending <= (latch_lo | latch_hi) ? 1'b1 : commit ? 1'b0 : pending;
    end
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with staged loads, increment and two-cycle page-crossing branches
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter logic [15:0] RESET_VEC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] data,
  input  logic              latch_lo,
  input  logic              latch_hi,
  input  logic              sync,
  input  logic              inc,
  input  logic              branch,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              page_cross,
  output logic              wrap
);
  localparam int HI_W = ADDR_W - BYTE_W;
  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_n, staged;
  logic                pending, commit, up, dn, pc_n, wrap_n;
  logic [BYTE_W:0]     sum;
  logic [HI_W-1:0]     hi;
  assign busy   = state != IDLE;
  assign commit = !busy && sync && pending;
  assign hi     = addr[ADDR_W-1:BYTE_W];
  assign sum    = {1'b0, addr[BYTE_W-1:0]} + {1'b0, data};
  // carry with a positive offset or no carry with a negative one leaves the page
  assign up     = !data[BYTE_W-1] && sum[BYTE_W];
  assign dn     = data[BYTE_W-1] && !sum[BYTE_W];
  pc_stage #(.ADDR_W(ADDR_W)) u_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (!busy),
    .data     (data),
    .latch_lo (latch_lo),
    .latch_hi (latch_hi),
    .commit   (commit),
    .staged   (staged),
    .pending  (pending)
  );
  always_comb begin
    state_n = IDLE;
    addr_n  = addr;
    pc_n    = 1'b0;
    wrap_n  = 1'b0;
    case (state)
      IDLE: begin
        if (commit) addr_n = staged;
        else if (branch) begin
          addr_n  = {hi, sum[BYTE_W-1:0]};
          pc_n    = up | dn;
          state_n = up ? FIX_UP : dn ? FIX_DN : IDLE;
        end else if (inc) begin
          addr_n = addr + ADDR_W'(1);
          wrap_n = &addr;
        end
      end
      FIX_UP:  addr_n = {hi + HI_W'(1), addr[BYTE_W-1:0]};
      FIX_DN:  addr_n = {hi - HI_W'(1), addr[BYTE_W-1:0]};
      default: state_n = IDLE;
    endcase
  end
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= RESET_VEC[ADDR_W-1:0];
      page_cross <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      page_cross <= pc_n;
      wrap       <= wrap_n;
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized checks of pc_unit against an arithmetic reference model
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data = '0;
  logic        latch_lo = 1'b0, latch_hi = 1'b0, sync = 1'b0, inc = 1'b0, branch = 1'b0;
  logic [15:0] addr;
  logic        busy, page_cross, wrap;
  int checks = 0, errors = 0;
  int m_addr, m_lo, m_hi, m_pend, m_fix, m_pc, m_wrap;

  pc_unit #(.ADDR_W(16), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .latch_lo(latch_lo), .latch_hi(latch_hi),
    .sync(sync), .inc(inc), .branch(branch), .addr(addr), .busy(busy),
    .page_cross(page_cross), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic model(input logic r, input logic [7:0] d, input logic ll, lh, sy, in, br);
    int s, com;
    m_pc = 0;
    m_wrap = 0;
    if (!r) begin
      m_addr = 0; m_lo = 0; m_hi = 0; m_pend = 0; m_fix = 0;
    end else if (m_fix != 0) begin
      m_addr = (m_addr + m_fix * 256) & 16'hFFFF;
      m_fix = 0;
    end else begin
      com = sy && m_pend;
      if (com) m_addr = m_hi * 256 + m_lo;
      else if (br) begin
        s = (m_addr & 255) + int'($signed(d));
        m_addr = (m_addr & 16'hFF00) | (s & 255);
        m_fix = s > 255 ? 1 : s < 0 ? -1 : 0;
        m_pc = m_fix != 0;
      end else if (in) begin
        m_wrap = m_addr == 16'hFFFF;
        m_addr = (m_addr + 1) & 16'hFFFF;
      end
      if (ll) m_lo = d;
      if (lh) m_hi = d;
      if (ll || lh) m_pend = 1;
      else if (com) m_pend = 0;
    end
  endtask

  task automatic cyc(input logic r, input logic [7:0] d, input logic ll, lh, sy, in, br);
    @(posedge clk);
    rst_n = r; data = d; latch_lo = ll; latch_hi = lh; sync = sy; inc = in; branch = br;
    @(negedge clk);
    model(r, d, ll, lh, sy, in, br);
    #1;
  endtask

  task automatic load(input logic [15:0] a);
    cyc(1, a[7:0], 1, 0, 0, 0, 0);
    cyc(1, a[15:8], 0, 1, 0, 0, 0);
    cyc(1, 8'h00, 0, 0, 1, 0, 0);
  endtask

  task automatic test_reset;
    cyc(0, 8'hAA, 1, 1, 1, 1, 1);
    checks++;
    if (addr !== 16'h0000 || busy !== 1'b0 || page_cross !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset: addr=%h busy=%b pc=%b wrap=%b, want 0000 0 0 0", addr, busy, page_cross, wrap);
    end
    cyc(1, 8'h00, 0, 0, 1, 0, 0);
    checks++;
    if (addr !== 16'h0000) begin
      errors++;
      $display("FAIL sync_no_pending: addr=%h want 0000", addr);
    end
  endtask

  task automatic test_load;
    cyc(1, 8'h34, 1, 0, 0, 0, 0);
    cyc(1, 8'h12, 0, 1, 0, 0, 0);
    cyc(1, 8'h00, 0, 0, 1, 0, 0);
    checks++;
    if (addr !== 16'h1234 || dut.u_stage.pending !== 1'b0) begin
      errors++;
      $display("FAIL load: addr=%h pending=%b want 1234 0", addr, dut.u_stage.pending);
    end
  endtask

  task automatic test_branch_up;
    load(16'h10F0);
    cyc(1, 8'h20, 0, 0, 0, 0, 1);
    checks++;
    if (addr !== 16'h1010 || page_cross !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL branch_up1: addr=%h pc=%b busy=%b want 1010 1 1", addr, page_cross, busy);
    end
    cyc(1, 8'h00, 0, 0, 0, 0, 0);
    checks++;
    if (addr !== 16'h1110 || page_cross !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL branch_up2: addr=%h pc=%b busy=%b want 1110 0 0", addr, page_cross, busy);
    end
  endtask

  task automatic test_branch_dn;
    load(16'h1005);
    cyc(1, 8'hF0, 0, 0, 0, 0, 1);
    checks++;
    if (addr !== 16'h10F5 || page_cross !== 1'b1) begin
      errors++;
      $display("FAIL branch_dn1: addr=%h pc=%b want 10F5 1", addr, page_cross);
    end
    cyc(1, 8'h00, 0, 0, 0, 0, 0);
    checks++;
    if (addr !== 16'h0FF5) begin
      errors++;
      $display("FAIL branch_dn2: addr=%h want 0FF5", addr);
    end
  endtask

  task automatic test_branch_same;
    load(16'h1005);
    cyc(1, 8'h05, 0, 0, 0, 0, 1);
    checks++;
    if (addr !== 16'h100A || busy !== 1'b0 || page_cross !== 1'b0) begin
      errors++;
      $display("FAIL branch_same: addr=%h busy=%b pc=%b want 100A 0 0", addr, busy, page_cross);
    end
  endtask

  task automatic test_wrap;
    load(16'hFFFE);
    cyc(1, 8'h00, 0, 0, 0, 1, 0);
    checks++;
    if (addr !== 16'hFFFF || wrap !== 1'b0) begin
      errors++;
      $display("FAIL inc_no_wrap: addr=%h wrap=%b want FFFF 0", addr, wrap);
    end
    cyc(1, 8'h00, 0, 0, 0, 1, 0);
    checks++;
    if (addr !== 16'h0000 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap: addr=%h wrap=%b want 0000 1", addr, wrap);
    end
    cyc(1, 8'h00, 0, 0, 0, 0, 0);
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pulse: wrap=%b want 0", wrap);
    end
  endtask

  task automatic test_latch_sync;
    load(16'h2040);
    cyc(1, 8'h77, 1, 0, 1, 1, 0);
    checks++;
    if (addr !== 16'h2041 || dut.u_stage.pending !== 1'b1) begin
      errors++;
      $display("FAIL latch_sync: addr=%h pending=%b want 2041 1", addr, dut.u_stage.pending);
    end
    cyc(1, 8'h00, 0, 0, 1, 0, 0);
    checks++;
    if (addr !== 16'h2077) begin
      errors++;
      $display("FAIL latch_sync_commit: addr=%h want 2077", addr);
    end
  endtask

  task automatic test_busy_ignore;
    load(16'h30F8);
    cyc(1, 8'h10, 0, 0, 0, 0, 1);
    cyc(1, 8'h99, 1, 1, 1, 1, 1);
    checks++;
    if (addr !== 16'h3108 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: addr=%h busy=%b want 3108 0", addr, busy);
    end
    cyc(1, 8'h00, 0, 0, 1, 0, 0);
    checks++;
    if (addr !== 16'h3108 || dut.u_stage.pending !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_latch: addr=%h pending=%b want 3108 0", addr, dut.u_stage.pending);
    end
  endtask

  task automatic test_reset_fix;
    load(16'h10F0);
    cyc(1, 8'h20, 0, 0, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 0, 0, 0);
    checks++;
    if (addr !== 16'h0000 || busy !== 1'b0 || page_cross !== 1'b0) begin
      errors++;
      $display("FAIL reset_fix: addr=%h busy=%b pc=%b want 0000 0 0", addr, busy, page_cross);
    end
    cyc(1, 8'h00, 0, 0, 0, 0, 0);
    checks++;
    if (addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_fix_hold: addr=%h want 0000", addr);
    end
  endtask

  task automatic test_random;
    logic [7:0] d;
    for (int i = 0; i < 3000; i++) begin
      d = 8'($urandom);
      cyc($urandom_range(0, 60) != 0, d, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      checks++;
      if (addr !== 16'(m_addr)) begin
        errors++;
        $display("FAIL rand_addr[%0d]: addr=%h want %h", i, addr, 16'(m_addr));
      end
      checks++;
      if (busy !== (m_fix != 0)) begin
        errors++;
        $display("FAIL rand_busy[%0d]: busy=%b want %b", i, busy, m_fix != 0);
      end
      checks++;
      if (page_cross !== 1'(m_pc) || wrap !== 1'(m_wrap)) begin
        errors++;
        $display("FAIL rand_flags[%0d]: pc=%b wrap=%b want %b %b", i, page_cross, wrap, 1'(m_pc), 1'(m_wrap));
      end
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_branch_up;
    test_branch_dn;
    test_branch_same;
    test_wrap;
    test_latch_sync;
    test_busy_ignore;
    test_reset_fix;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
